// File: rtl/jtframe_sdram_rrarb.sv
// jtframe_sdram_rrarb
// Round-robin arbiter sharing one SDRAM controller port among NSLOTS requesters.
// Latches the winner's command, routes data strobes back to the granted slot only,
// and aborts an access that sees no data_rdy within TIMEOUT cycles (0 = no watchdog).
// Optional feature macro: JTFRAME_SDRAM_RRARB_PRIO0_EN
//   defined     -> slot 0 wins whenever it is eligible; slots 1..NSLOTS-1 rotate.
//   not defined -> all slots rotate fairly.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no access in flight, waiting for a request
// CMD   | sdram_rd/sdram_wr asserted, waiting for sdram_ack
// WAIT  | command accepted, waiting for data_rdy
module jtframe_sdram_rrarb #(
  parameter int SDRAMW  = 22,
  parameter int NSLOTS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSLOTS-1:0]        slot_req,
  input  logic [NSLOTS-1:0]        slot_we,
  input  logic [NSLOTS*SDRAMW-1:0] slot_addr,
  input  logic [NSLOTS*16-1:0]     slot_din,
  input  logic [NSLOTS*2-1:0]      slot_wrmask,
  output logic [NSLOTS-1:0]        slot_sel,
  output logic [NSLOTS-1:0]        slot_ok,
  output logic [NSLOTS-1:0]        slot_dst,
  output logic [NSLOTS-1:0]        slot_err,
  input  logic                     sdram_ack,
  input  logic                     data_rdy,
  input  logic                     data_dst,
  output logic                     sdram_rd,
  output logic                     sdram_wr,
  output logic [SDRAMW-1:0]        sdram_addr,
  output logic [15:0]              data_write,
  output logic [1:0]               sdram_wrmask
);

  localparam int PW  = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST   = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0]  LAST_SLOT = PW'(NSLOTS - 1);

  generate
    if (NSLOTS < 2 || NSLOTS > 8) begin : g_nslots_check
      $error("jtframe_sdram_rrarb: NSLOTS must be in the range 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NSLOTS-1:0]   r_sel,   w_sel_nxt;
  logic [NSLOTS-1:0]   r_err,   w_err_nxt;
  logic                r_rd,    w_rd_nxt;
  logic                r_wr,    w_wr_nxt;
  logic [SDRAMW-1:0]   r_addr,  w_addr_nxt;
  logic [15:0]         r_dw,    w_dw_nxt;
  logic [1:0]          r_mask,  w_mask_nxt;
  logic [PW-1:0]       r_ptr,   w_ptr_nxt;
  logic [WDW-1:0]      r_wd,    w_wd_nxt;

  logic [NSLOTS-1:0]   w_active;
  logic [NSLOTS-1:0]   w_cand;
  logic                w_found;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_win_inc;
  logic                w_done;
  logic                w_tmo;
  logic                w_issue;

  // The slot being served is excluded, so it cannot win its own done cycle
  assign w_active = slot_req & ~r_sel;

`ifdef JTFRAME_SDRAM_RRARB_PRIO0_EN
  assign w_cand = w_active & ~NSLOTS'(1);
`else
  assign w_cand = w_active;
`endif

  // Winner search: first candidate at or above the pointer, wrapping to slot 0
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (!w_found && w_cand[(int'(r_ptr) + k) % NSLOTS]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_ptr) + k) % NSLOTS);
      end
    end
`ifdef JTFRAME_SDRAM_RRARB_PRIO0_EN
    if (w_active[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  assign w_win_inc = (w_win == LAST_SLOT) ? '0 : w_win + 1'b1;

  // data_rdy while the command is still pending counts as ack and completion at once
  assign w_done = (r_state != IDLE) && data_rdy;
  assign w_tmo  = (TIMEOUT > 0) && (r_state != IDLE) && !w_done && (r_wd == WD_LAST);

  // Next-state and next-register computation
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_err_nxt   = '0;
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_dw_nxt    = r_dw;
    w_mask_nxt  = r_mask;
    w_ptr_nxt   = r_ptr;
    w_wd_nxt    = r_wd;
    w_issue     = 1'b0;

    case (r_state)
      IDLE: begin
        w_issue = w_found;
      end
      CMD, WAIT: begin
        if (w_done) begin
          // Back-to-back issue when someone else is waiting, otherwise release
          w_issue = w_found;
          if (!w_found) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            w_rd_nxt    = 1'b0;
            w_wr_nxt    = 1'b0;
            w_wd_nxt    = '0;
          end
        end else if (w_tmo) begin
          w_state_nxt = IDLE;
          w_err_nxt   = r_sel;
          w_sel_nxt   = '0;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_wd_nxt    = '0;
        end else begin
          if (r_state == CMD && sdram_ack) begin
            w_state_nxt = WAIT;
            w_rd_nxt    = 1'b0;
            w_wr_nxt    = 1'b0;
          end
          if (TIMEOUT > 0) begin
            w_wd_nxt = r_wd + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = '0;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_wd_nxt    = '0;
      end
    endcase

    if (w_issue) begin
      w_state_nxt = CMD;
      w_sel_nxt   = NSLOTS'(1) << w_win;
      w_rd_nxt    = ~slot_we[w_win];
      w_wr_nxt    = slot_we[w_win];
      w_addr_nxt  = slot_addr[int'(w_win)*SDRAMW +: SDRAMW];
      w_dw_nxt    = slot_din[int'(w_win)*16 +: 16];
      w_mask_nxt  = slot_we[w_win] ? slot_wrmask[int'(w_win)*2 +: 2] : 2'b11;
      w_wd_nxt    = '0;
`ifdef JTFRAME_SDRAM_RRARB_PRIO0_EN
      // Slot 0 grants leave the rotation among the other slots untouched
      if (w_win != '0) begin
        w_ptr_nxt = w_win_inc;
      end
`else
      w_ptr_nxt = w_win_inc;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, command, watchdog and rotation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_err  <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_dw   <= '0;
      r_mask <= 2'b11;
      r_ptr  <= '0;
      r_wd   <= '0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_err  <= w_err_nxt;
      r_rd   <= w_rd_nxt;
      r_wr   <= w_wr_nxt;
      r_addr <= w_addr_nxt;
      r_dw   <= w_dw_nxt;
      r_mask <= w_mask_nxt;
      r_ptr  <= w_ptr_nxt;
      r_wd   <= w_wd_nxt;
    end
  end

  assign slot_sel     = r_sel;
  assign slot_ok      = {NSLOTS{data_rdy}} & r_sel;
  assign slot_dst     = {NSLOTS{data_dst}} & r_sel;
  assign slot_err     = r_err;
  assign sdram_rd     = r_rd;
  assign sdram_wr     = r_wr;
  assign sdram_addr   = r_addr;
  assign data_write   = r_dw;
  assign sdram_wrmask = r_mask;

endmodule

// File: tb/tb_jtframe_sdram_rrarb.sv
// Testbench for jtframe_sdram_rrarb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_jtframe_sdram_rrarb;
  localparam int SW  = 22;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    slot_req, slot_we, slot_sel, slot_ok, slot_dst, slot_err;
  logic [N*SW-1:0] slot_addr;
  logic [N*16-1:0] slot_din;
  logic [N*2-1:0]  slot_wrmask;
  logic            sdram_ack, data_rdy, data_dst, sdram_rd, sdram_wr;
  logic [SW-1:0]   sdram_addr;
  logic [15:0]     data_write;
  logic [1:0]      sdram_wrmask;

  jtframe_sdram_rrarb #(.SDRAMW(SW), .NSLOTS(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .slot_req(slot_req), .slot_we(slot_we), .slot_addr(slot_addr),
    .slot_din(slot_din), .slot_wrmask(slot_wrmask),
    .slot_sel(slot_sel), .slot_ok(slot_ok), .slot_dst(slot_dst), .slot_err(slot_err),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_dst(data_dst),
    .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_addr(sdram_addr),
    .data_write(data_write), .sdram_wrmask(sdram_wrmask)
  );

  int n_chk = 0;
  int n_pass = 0;

  // requesters
  bit            b_req [N];
  bit            b_we  [N];
  logic [SW-1:0] b_addr[N];
  logic [15:0]   b_din [N];
  logic [1:0]    b_msk [N];

  // transaction-level model: which slot owns the port, and whether its command is pending
  int            m_busy, m_ptr, m_cnt, m_err;
  bit            m_cmd, m_we;
  logic [SW-1:0] m_addr;
  logic [15:0]   m_dw;
  logic [1:0]    m_mask;

  // controller emulation
  int c_age, c_wait, c_ack_lat, c_rdy_lat;
  bit c_stuck, c_early;
  bit rnd, f_stuck, force_late;
  int f_ack, f_rdy;

  // snapshots of the last checked cycle
  logic [N-1:0]  s_sel, s_ok, s_err;
  logic          s_rd, s_wr;
  bit   [N-1:0]  e_fin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = -1; m_ptr = 0; m_cnt = 0; m_err = -1;
    m_cmd = 0; m_we = 0; m_addr = '0; m_dw = '0; m_mask = 2'b11;
    c_age = 0; c_wait = 0; c_ack_lat = 0; c_rdy_lat = 1; c_stuck = 0; c_early = 0;
  endtask

  function automatic bit elig(input int i);
    return b_req[i] && (i != m_busy);
  endfunction

  task automatic pick(output int w);
    w = -1;
`ifdef JTFRAME_SDRAM_RRARB_PRIO0_EN
    if (elig(0)) begin
      w = 0;
      return;
    end
`endif
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
`ifdef JTFRAME_SDRAM_RRARB_PRIO0_EN
      if (c == 0) continue;
`endif
      if (elig(c)) begin
        w = c;
        m_ptr = (c + 1) % N;
        return;
      end
    end
  endtask

  task automatic issue(input int w);
    m_busy = w; m_cmd = 1; m_we = b_we[w];
    m_addr = b_addr[w]; m_dw = b_din[w];
    m_mask = b_we[w] ? b_msk[w] : 2'b11;
    m_cnt = 0; c_age = 0; c_wait = 0;
    if (rnd) begin
      c_ack_lat = $urandom_range(0, 3);
      c_rdy_lat = $urandom_range(1, 6);
      c_stuck   = ($urandom % 10) == 0;
      c_early   = !c_stuck && (($urandom % 8) == 0);
    end else begin
      c_ack_lat = f_ack; c_rdy_lat = f_rdy; c_stuck = f_stuck; c_early = 0;
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      slot_req[i] = b_req[i];
      slot_we[i]  = b_we[i];
      slot_addr[i*SW +: SW]  = b_addr[i];
      slot_din[i*16 +: 16]   = b_din[i];
      slot_wrmask[i*2 +: 2]  = b_msk[i];
    end
  endtask

  task automatic drive_ctrl();
    sdram_ack = 0;
    data_rdy  = 0;
    data_dst  = rnd ? 1'($urandom % 2) : 1'b0;
    if (m_busy >= 0) begin
      if (m_cmd) begin
        sdram_ack = (c_age >= c_ack_lat);
        if (c_early && c_age == 0) data_rdy = 1;
      end else if (!c_stuck && c_wait >= c_rdy_lat) begin
        data_rdy = 1;
      end
    end else if ((force_late && m_err >= 0) || (rnd && ($urandom % 10) == 0)) begin
      data_rdy = 1;
    end
  endtask

  // one clock: drive, check at the falling edge, advance the model, settle after the rising edge
  task automatic cycle();
    logic [N-1:0] e_sel, e_ok, e_dst, e_err;
    bit done, tmo;
    int w;
    pack();
    drive_ctrl();
    @(negedge clk);
    e_sel = '0; e_err = '0;
    if (m_busy >= 0) e_sel[m_busy] = 1'b1;
    if (m_err >= 0)  e_err[m_err]  = 1'b1;
    e_ok  = data_rdy ? e_sel : '0;
    e_dst = data_dst ? e_sel : '0;
    chk("slot_sel", slot_sel, e_sel);
    chk("slot_ok", slot_ok, e_ok);
    chk("slot_dst", slot_dst, e_dst);
    chk("slot_err", slot_err, e_err);
    chk("sdram_rd", sdram_rd, m_cmd && !m_we);
    chk("sdram_wr", sdram_wr, m_cmd && m_we);
    chk("sdram_addr", sdram_addr, m_addr);
    chk("data_write", data_write, m_dw);
    chk("sdram_wrmask", sdram_wrmask, m_mask);
    s_sel = slot_sel; s_ok = slot_ok; s_err = slot_err; s_rd = sdram_rd; s_wr = sdram_wr;
    e_fin = e_ok | e_err;

    done = (m_busy >= 0) && data_rdy;
    tmo  = (m_busy >= 0) && !done && (m_cnt == TMO - 1);
    m_err = -1;
    if (m_busy < 0 || done) begin
      pick(w);
      if (w >= 0) issue(w);
      else begin
        m_busy = -1; m_cmd = 0; m_cnt = 0;
      end
    end else if (tmo) begin
      m_err = m_busy; m_busy = -1; m_cmd = 0; m_cnt = 0;
    end else begin
      if (m_cmd) begin
        if (sdram_ack) begin
          m_cmd = 0; c_wait = 1;
        end else c_age++;
      end else c_wait++;
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] g[$];
    logic [N-1:0] exp_ord[5];
    int idle_cnt, zeros, wr_cyc, t_iss, t_err;
    bit prev_cmd, found;

    model_reset();
    rnd = 0; f_ack = 0; f_rdy = 4; f_stuck = 0; force_late = 0;
    for (int i = 0; i < N; i++) begin
      b_req[i] = 0; b_we[i] = 0; b_addr[i] = '0; b_din[i] = '0; b_msk[i] = 2'b11;
    end
    pack();
    sdram_ack = 0; data_rdy = 0; data_dst = 0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", slot_sel, 0);
    chk("rst_err", slot_err, 0);
    chk("rst_rd", sdram_rd, 0);
    chk("rst_wr", sdram_wr, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_dw", data_write, 0);
    chk("rst_mask", sdram_wrmask, 2'b11);
    @(posedge clk); #1;
    rst_n = 1;

    // all slots read continuously: ack immediately, data 4 cycles later
    for (int i = 0; i < N; i++) begin
      b_req[i] = 1; b_we[i] = 0; b_addr[i] = SW'($urandom); b_din[i] = 16'($urandom);
    end
    idle_cnt = 0; prev_cmd = 0;
    for (int k = 0; k < 300 && g.size() < 17; k++) begin
      cycle();
      if ((s_rd || s_wr) && !prev_cmd) g.push_back(s_sel);
      if (g.size() > 0 && s_sel == 0) idle_cnt++;
      prev_cmd = s_rd || s_wr;
    end
    chk("grant_count", g.size(), 17);
`ifdef JTFRAME_SDRAM_RRARB_PRIO0_EN
    exp_ord = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001};
`else
    exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    if (g.size() >= 17) begin
      for (int k = 0; k < 5; k++) chk($sformatf("grant_order_%0d", k), g[k], exp_ord[k]);
      zeros = 0;
      for (int k = 1; k <= 16; k++) if (g[k] == 4'b0001) zeros++;
`ifdef JTFRAME_SDRAM_RRARB_PRIO0_EN
      chk("slot0_share", zeros, 8);
`else
      chk("slot0_share", zeros, 4);
`endif
    end
    chk("idle_gaps", idle_cnt, 0);
    for (int i = 0; i < N; i++) b_req[i] = 0;
    repeat (12) cycle();

    // write path on slot 2
    f_ack = 2; f_rdy = 3;
    b_req[2] = 1; b_we[2] = 1; b_addr[2] = 22'h1234; b_din[2] = 16'hBEEF; b_msk[2] = 2'b01;
    cycle();
    cycle();
    chk("wr_sel", s_sel, 4'b0100);
    chk("wr_wr", sdram_wr, 1);
    chk("wr_rd", sdram_rd, 0);
    chk("wr_addr", sdram_addr, 22'h1234);
    chk("wr_data", data_write, 16'hBEEF);
    chk("wr_mask", sdram_wrmask, 2'b01);
    wr_cyc = 1; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_wr) wr_cyc++;
      if (s_ok != 0) begin
        found = 1;
        chk("wr_ok", s_ok, 4'b0100);
      end
    end
    chk("wr_done_seen", found, 1);
    chk("wr_held_cycles", wr_cyc, 3);
    b_req[2] = 0; b_we[2] = 0;
    repeat (4) cycle();

    // watchdog on slot 1, data never arrives; a late data_rdy lands on the error cycle
    f_ack = 1; f_rdy = 3; f_stuck = 1; force_late = 1;
    b_req[1] = 1; b_we[1] = 0; b_addr[1] = 22'h2A5A5;
    t_iss = -1; t_err = -1;
    for (int k = 0; k < 40 && t_err < 0; k++) begin
      cycle();
      if (t_iss < 0 && s_rd) t_iss = k;
      if (s_err != 0) begin
        t_err = k;
        chk("wd_err_slot", s_err, 4'b0010);
        chk("wd_late_ok", s_ok, 0);
      end
    end
    chk("wd_latency", t_err - t_iss, 8);
    b_req[1] = 0; force_late = 0; f_stuck = 0;
    repeat (12) cycle();

    // reset while slot 3 waits for data
    f_ack = 0; f_rdy = 6;
    b_req[3] = 1; b_we[3] = 0; b_addr[3] = 22'h3F0F0;
    repeat (4) cycle();
    chk("pre_rst_sel", slot_sel, 4'b1000);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_sel", slot_sel, 0);
    chk("mid_rst_rd", sdram_rd, 0);
    chk("mid_rst_wr", sdram_wr, 0);
    chk("mid_rst_addr", sdram_addr, 0);
    chk("mid_rst_dw", data_write, 0);
    chk("mid_rst_mask", sdram_wrmask, 2'b11);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < N; i++) b_req[i] = 1;
    cycle();
    cycle();
    chk("post_rst_grant", s_sel, 4'b0001);
    for (int i = 0; i < N; i++) b_req[i] = 0;
    repeat (10) cycle();

    // randomized traffic against the model
    rnd = 1;
    for (int k = 0; k < 3000; k++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (e_fin[i]) b_req[i] = 0;
        else if (!b_req[i] && ($urandom % 3) == 0) begin
          b_req[i]  = 1;
          b_we[i]   = 1'($urandom % 2);
          b_addr[i] = SW'($urandom);
          b_din[i]  = 16'($urandom);
          b_msk[i]  = 2'($urandom);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
